// File: rtl/conv_pool_engine.sv
// 3x3 zero-padded convolution with bias, ReLU and saturation into layer 0 (csel=1),
// followed by optional 2x2 stride-2 max pooling into layer 1 (csel=3).
module conv_pool_engine #(
  parameter int AW   = 6,
  parameter int DW   = 20,
  parameter int FRAC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              pool_en,
  input  logic              kwr,
  input  logic [3:0]        kaddr,
  input  logic [DW-1:0]     kdata,
  output logic              busy,
  output logic [2*AW-1:0]   iaddr,
  input  logic [DW-1:0]     idata,
  output logic              crd,
  output logic [2*AW-1:0]   caddr_rd,
  input  logic [DW-1:0]     cdata_rd,
  output logic              cwr,
  output logic [2*AW-1:0]   caddr_wr,
  output logic [DW-1:0]     cdata_wr,
  output logic [2:0]        csel
);

  localparam int N     = 1 << AW;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = 2 * DW + 4;

  localparam logic [AW-1:0]          X_LAST      = AW'(N - 1);
  localparam logic [AW-1:0]          X_LAST_POOL = AW'(N - 2);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX    = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
  localparam logic [DW-1:0]          RES_MAX     = {1'b0, {(DW-1){1'b1}}};

  // K0..K8 then bias, in 20-bit two's complement.
  localparam logic [19:0] K_DEFAULT [10] = '{
    20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
    20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19, 20'h01310
  };

  typedef enum logic [2:0] {
    IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_MAX, POOL_WR, DONE
  } state_t;

  state_t                   state, next_state;
  logic [AW-1:0]            x, y;
  logic [3:0]               cnt;
  logic                     pool_q;
  logic signed [DW-1:0]     kreg [10];
  logic signed [DW-1:0]     idata_q;
  logic signed [ACC_W-1:0]  acc, term, rounded;
  logic signed [PW-1:0]     prod;
  logic [3:0]               acc_tap;
  logic [DW-1:0]            conv_result;
  logic signed [DW-1:0]     pool_max;
  logic signed [DW-1:0]     rd_value;
  logic                     frame_last, pool_last;

  logic                     crd_d, cwr_d;
  logic [2:0]               csel_d;
  logic [2*AW-1:0]          caddr_rd_d, caddr_wr_d;
  logic [DW-1:0]            cdata_wr_d;

  // Tap k as {row, col}, each 0..2 meaning offset -1..+1.
  function automatic logic [3:0] tap_offsets(input logic [3:0] k);
    case (k)
      4'd0:    return {2'd0, 2'd0};
      4'd1:    return {2'd0, 2'd1};
      4'd2:    return {2'd0, 2'd2};
      4'd3:    return {2'd1, 2'd0};
      4'd4:    return {2'd1, 2'd1};
      4'd5:    return {2'd1, 2'd2};
      4'd6:    return {2'd2, 2'd0};
      4'd7:    return {2'd2, 2'd1};
      4'd8:    return {2'd2, 2'd2};
      default: return {2'd1, 2'd1};
    endcase
  endfunction

  function automatic logic tap_inside(input logic [3:0] k, input logic [AW-1:0] px,
                                      input logic [AW-1:0] py);
    logic [1:0] r, c;
    {r, c} = tap_offsets(k);
    return !((r == 2'd0 && py == '0) || (r == 2'd2 && py == X_LAST) ||
             (c == 2'd0 && px == '0) || (c == 2'd2 && px == X_LAST));
  endfunction

  function automatic logic [2*AW-1:0] tap_addr(input logic [3:0] k, input logic [AW-1:0] px,
                                              input logic [AW-1:0] py);
    logic [1:0] r, c;
    {r, c} = tap_offsets(k);
    return {py + AW'(r) - AW'(1), px + AW'(c) - AW'(1)};
  endfunction

  assign frame_last = (x == X_LAST) && (y == X_LAST);
  assign pool_last  = (x == X_LAST_POOL) && (y == X_LAST_POOL);
  assign acc_tap    = cnt - 4'd2;
  assign prod       = PW'(idata_q) * PW'(kreg[acc_tap]);
  assign rounded    = (acc + ROUND_HALF) >>> FRAC;
  assign rd_value   = $signed(cdata_rd);

  // Out-of-image taps were still fetched (wrapped address) but contribute nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    term = '0;
    if (state == CONV_RD) begin
      if (cnt >= 4'd2 && cnt <= 4'd10 && tap_inside(acc_tap, x, y)) begin
        term = ACC_W'(prod);
      end else if (cnt == 4'd11) begin
        term = ACC_W'(kreg[9]) <<< FRAC;
      end
    end
  end

  always_comb begin
    conv_result = rounded[DW-1:0];
    if (acc < 0) begin
      conv_result = '0;
    end else if (rounded > SAT_MAX) begin
      conv_result = RES_MAX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (ready) next_state = CONV_RD;
      CONV_RD:  if (cnt == 4'd11) next_state = CONV_WR;
      CONV_WR: begin
        if (!frame_last)  next_state = CONV_RD;
        else if (pool_q)  next_state = POOL_RD;
        else              next_state = DONE;
      end
      POOL_RD:  if (cnt == 4'd4) next_state = POOL_MAX;
      POOL_MAX: next_state = POOL_WR;
      POOL_WR:  next_state = pool_last ? DONE : POOL_RD;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Memory-port values are computed here and registered below, so each strobe
  // appears on the port the cycle after its state.
  always_comb begin
    busy       = 1'b0;
    iaddr      = '0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = 3'd0;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    case (state)
      CONV_RD: begin
        busy = 1'b1;
        if (cnt <= 4'd8) iaddr = tap_addr(cnt, x, y);
      end
      CONV_WR: begin
        busy       = 1'b1;
        cwr_d      = 1'b1;
        csel_d     = 3'd1;
        caddr_wr_d = {y, x};
        cdata_wr_d = conv_result;
      end
      POOL_RD: begin
        busy = 1'b1;
        if (cnt <= 4'd3) begin
          crd_d      = 1'b1;
          csel_d     = 3'd1;
          caddr_rd_d = {y + AW'(cnt[1]), x + AW'(cnt[0])};
        end
      end
      POOL_MAX: busy = 1'b1;
      POOL_WR: begin
        busy       = 1'b1;
        cwr_d      = 1'b1;
        csel_d     = 3'd3;
        caddr_wr_d = {2'b00, y[AW-1:1], x[AW-1:1]};
        cdata_wr_d = pool_max;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      pool_q   <= 1'b0;
      idata_q  <= '0;
      acc      <= '0;
      pool_max <= '0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      // NOTE: the kernel file is ten flops, not a RAM, so reset can load the
      // defaults directly; the image and result memories stay outside and unreset.
      for (int i = 0; i < 10; i++) kreg[i] <= DW'($signed(K_DEFAULT[i]));
    end else begin
      // NOTE: all state here uses <= so every flop samples pre-edge values.
      cnt      <= (next_state == state) ? cnt + 4'd1 : 4'd0;
      idata_q  <= $signed(idata);
      crd      <= crd_d;
      cwr      <= cwr_d;
      csel     <= csel_d;
      caddr_rd <= caddr_rd_d;
      caddr_wr <= caddr_wr_d;
      cdata_wr <= cdata_wr_d;

      case (state)
        IDLE: begin
          if (kwr && kaddr <= 4'd9) kreg[kaddr] <= $signed(kdata);
          if (ready) begin
            x      <= '0;
            y      <= '0;
            pool_q <= pool_en;
          end
        end
        CONV_RD: begin
          if (cnt == 4'd0) acc <= '0;
          else             acc <= acc + term;
        end
        CONV_WR: begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y + AW'(1);
          end else begin
            x <= x + AW'(1);
          end
        end
        POOL_RD: begin
          if (cnt == 4'd2) pool_max <= rd_value;
          else if (cnt > 4'd2 && rd_value > pool_max) pool_max <= rd_value;
        end
        POOL_MAX: if (rd_value > pool_max) pool_max <= rd_value;
        POOL_WR: begin
          if (x == X_LAST_POOL) begin
            x <= '0;
            y <= y + AW'(2);
          end else begin
            x <= x + AW'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed-sequence bench for conv_pool_engine on an 8x8 image with random pixel and
// kernel data, checked against an arithmetic model of convolution and pooling.
module tb_conv_pool_engine;

  localparam int AW          = 3;
  localparam int DW          = 20;
  localparam int FRAC        = 16;
  localparam int N           = 1 << AW;
  localparam int NN          = N * N;
  localparam int NQ          = NN / 4;
  localparam int CONV_CYCLES = 13 * NN;
  localparam int POOL_CYCLES = 7 * NQ;
  localparam int WAIT_LIMIT  = 4000;

  localparam logic [19:0] K_DEF [10] = '{
    20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
    20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19, 20'h01310
  };

  logic              clk = 1'b0;
  logic              reset, ready, pool_en, kwr;
  logic [3:0]        kaddr;
  logic [DW-1:0]     kdata;
  logic              busy;
  logic [2*AW-1:0]   iaddr;
  logic [DW-1:0]     idata;
  logic              crd;
  logic [2*AW-1:0]   caddr_rd;
  logic [DW-1:0]     cdata_rd;
  logic              cwr;
  logic [2*AW-1:0]   caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic [2:0]        csel;

  always #5 clk = ~clk;

  conv_pool_engine #(.AW(AW), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .ready(ready), .pool_en(pool_en),
    .kwr(kwr), .kaddr(kaddr), .kdata(kdata), .busy(busy),
    .iaddr(iaddr), .idata(idata), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  logic signed [19:0] img  [NN];
  logic signed [19:0] kmod [10];
  logic [19:0] l0_mem [NN];
  logic [19:0] l1_mem [NN];
  int          l0_stamp [NN];
  int          l1_stamp [NN];
  logic [19:0] exp_l0 [NN];
  logic [19:0] exp_l1 [NQ];
  int frame_id = 0;

  int l0_writes = 0, l1_writes = 0, l1_oob = 0, csel3_total = 0, busy_total = 0, clash = 0;
  int b0, w0, v0, q0;
  int checks = 0, errors = 0;

  // Image ROM and result memory, one-cycle read latency.
  always @(posedge clk) begin
    idata <= img[iaddr];
    if (crd && csel == 3'd1) cdata_rd <= l0_mem[caddr_rd];
    if (cwr && csel == 3'd1) begin
      l0_mem[caddr_wr]   <= cdata_wr;
      l0_stamp[caddr_wr] <= frame_id;
      l0_writes          <= l0_writes + 1;
    end
    if (cwr && csel == 3'd3) begin
      l1_mem[caddr_wr]   <= cdata_wr;
      l1_stamp[caddr_wr] <= frame_id;
      l1_writes          <= l1_writes + 1;
      if (caddr_wr >= 6'(NQ)) l1_oob <= l1_oob + 1;
    end
    if (csel == 3'd3) csel3_total <= csel3_total + 1;
    if (busy)         busy_total  <= busy_total + 1;
    if (cwr && crd)   clash       <= clash + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] conv_ref(input int px, input int py);
    longint acc, r;
    acc = longint'(kmod[9]) * (longint'(1) <<< FRAC);
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        int yy, xx;
        yy = py + ky - 1;
        xx = px + kx - 1;
        if (yy >= 0 && yy < N && xx >= 0 && xx < N)
          acc += longint'(img[yy*N + xx]) * longint'(kmod[ky*3 + kx]);
      end
    end
    if (acc < 0) return 20'h0;
    r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (r > 524287) r = 524287;
    return r[19:0];
  endfunction

  task automatic compute_expected();
    for (int py = 0; py < N; py++)
      for (int px = 0; px < N; px++)
        exp_l0[py*N + px] = conv_ref(px, py);
    for (int oy = 0; oy < N/2; oy++) begin
      for (int ox = 0; ox < N/2; ox++) begin
        logic signed [19:0] m;
        int base;
        base = 2*oy*N + 2*ox;
        m = $signed(exp_l0[base]);
        if ($signed(exp_l0[base + 1])     > m) m = $signed(exp_l0[base + 1]);
        if ($signed(exp_l0[base + N])     > m) m = $signed(exp_l0[base + N]);
        if ($signed(exp_l0[base + N + 1]) > m) m = $signed(exp_l0[base + N + 1]);
        exp_l1[oy*(N/2) + ox] = m;
      end
    end
  endtask

  task automatic load_k(input int a, input logic [19:0] d);
    @(negedge clk);
    kwr = 1'b1; kaddr = 4'(a); kdata = d;
    @(negedge clk);
    kwr = 1'b0;
    if (a <= 9) kmod[a] = d;
  endtask

  task automatic load_identity();
    for (int i = 0; i < 10; i++) load_k(i, (i == 4) ? 20'h10000 : 20'h00000);
  endtask

  task automatic fill_image(input int mode);
    for (int i = 0; i < NN; i++) begin
      logic [31:0] r;
      r = $urandom();
      case (mode)
        0:       img[i] = 20'h00000;
        1:       img[i] = r[19:0];
        default: img[i] = 20'h7FFFF;
      endcase
    end
  endtask

  task automatic snapshot();
    b0 = busy_total; w0 = l0_writes; v0 = l1_writes; q0 = csel3_total;
    frame_id++;
  endtask

  task automatic start_frame(input bit pe);
    snapshot();
    @(negedge clk);
    ready = 1'b1; pool_en = pe;
    @(negedge clk);
    ready = 1'b0; pool_en = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, n < WAIT_LIMIT, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bit pe);
    int missing;
    compute_expected();
    for (int i = 0; i < NN; i++)
      check($sformatf("%s_l0[%0d]", tag, i), l0_mem[i], exp_l0[i]);
    missing = 0;
    for (int i = 0; i < NN; i++) if (l0_stamp[i] != frame_id) missing++;
    check({tag, "_l0_coverage"}, missing, 0);
    check({tag, "_l0_writes"}, l0_writes - w0, NN);
    check({tag, "_busy_cycles"}, busy_total - b0, pe ? CONV_CYCLES + POOL_CYCLES : CONV_CYCLES);
    if (pe) begin
      for (int i = 0; i < NQ; i++)
        check($sformatf("%s_l1[%0d]", tag, i), l1_mem[i], exp_l1[i]);
      missing = 0;
      for (int i = 0; i < NQ; i++) if (l1_stamp[i] != frame_id) missing++;
      check({tag, "_l1_coverage"}, missing, 0);
      check({tag, "_l1_writes"}, l1_writes - v0, NQ);
    end else begin
      check({tag, "_no_csel3"}, csel3_total - q0, 0);
      check({tag, "_no_l1_writes"}, l1_writes - v0, 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_crd"}, crd, 0);
    check({tag, "_cwr"}, cwr, 0);
    check({tag, "_csel"}, csel, 0);
    check({tag, "_iaddr"}, iaddr, 0);
    check({tag, "_caddr_rd"}, caddr_rd, 0);
    check({tag, "_caddr_wr"}, caddr_wr, 0);
    check({tag, "_cdata_wr"}, cdata_wr, 0);
  endtask

  initial begin
    logic [19:0] val;
    logic [31:0] r;

    reset = 1'b1; ready = 1'b0; pool_en = 1'b0; kwr = 1'b0; kaddr = 4'd0; kdata = '0;
    for (int i = 0; i < 10; i++) kmod[i] = K_DEF[i];
    fill_image(0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Zero image, default kernel: every output is the bias.
    start_frame(1'b0);
    wait_idle("zero");
    check_frame("zero", 1'b0);
    check("zero_const_l0[9]", l0_mem[9], 20'h01310);

    // Identity kernel passes positive pixels and clamps negative ones.
    load_identity();
    fill_image(1);
    start_frame(1'b0);
    wait_idle("ident");
    check_frame("ident", 1'b0);
    check("ident_corner", l0_mem[0], img[0][19] ? 20'h0 : img[0]);

    // All-ones kernel on a full-scale image must saturate, never wrap negative.
    for (int i = 0; i < 9; i++) load_k(i, 20'h10000);
    load_k(9, 20'h00000);
    fill_image(2);
    start_frame(1'b0);
    wait_idle("sat");
    check_frame("sat", 1'b0);
    check("sat_corner", l0_mem[0], 20'h7FFFF);
    check("sat_center_sign", l0_mem[N + 1][19], 0);

    // Identity kernel with pooling.
    load_identity();
    fill_image(1);
    start_frame(1'b1);
    wait_idle("pool_ident");
    check_frame("pool_ident", 1'b1);
    val = l0_mem[0];
    if ($signed(l0_mem[1])     > $signed(val)) val = l0_mem[1];
    if ($signed(l0_mem[N])     > $signed(val)) val = l0_mem[N];
    if ($signed(l0_mem[N + 1]) > $signed(val)) val = l0_mem[N + 1];
    check("pool_entry0", l1_mem[0], val);

    // Random small kernel; an out-of-range kaddr is ignored; bias written in the
    // same cycle as ready must be used by that frame.
    for (int i = 0; i < 9; i++) begin
      r = $urandom();
      load_k(i, {{4{r[15]}}, r[15:0]});
    end
    load_k(12, 20'hFFFFF);
    fill_image(1);
    r = $urandom();
    snapshot();
    @(negedge clk);
    kwr = 1'b1; kaddr = 4'd9; kdata = {{4{r[15]}}, r[15:0]}; ready = 1'b1; pool_en = 1'b1;
    kmod[9] = {{4{r[15]}}, r[15:0]};
    @(negedge clk);
    kwr = 1'b0; ready = 1'b0; pool_en = 1'b0;
    check("same_cycle_busy_rise", busy, 1);
    wait_idle("rand_k");
    check_frame("rand_k", 1'b1);

    // kwr and ready while busy are ignored; then a back-to-back frame without reset.
    fill_image(1);
    start_frame(1'b0);
    repeat (50) @(negedge clk);
    kwr = 1'b1; kaddr = 4'd4; kdata = 20'h3FFFF;
    @(negedge clk);
    kwr = 1'b0;
    repeat (100) @(negedge clk);
    ready = 1'b1; pool_en = 1'b1;
    @(negedge clk);
    ready = 1'b0; pool_en = 1'b0;
    wait_idle("busy_kwr");
    check_frame("busy_kwr", 1'b0);
    check("busy_kwr_idle", busy, 0);
    fill_image(1);
    start_frame(1'b1);
    wait_idle("back2back");
    check_frame("back2back", 1'b1);
    check("back2back_idle", busy, 0);

    // Asynchronous reset mid-convolution restores idle outputs and default kernel.
    fill_image(1);
    start_frame(1'b1);
    repeat (30 * 13) @(negedge clk);
    reset = 1'b1;
    #2;
    check_outputs_zero("midreset");
    @(negedge clk);
    check_outputs_zero("midreset_next");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) kmod[i] = K_DEF[i];
    @(negedge clk);
    fill_image(1);
    start_frame(1'b1);
    wait_idle("after_reset");
    check_frame("after_reset", 1'b1);

    check("never_cwr_and_crd", clash, 0);
    check("l1_addr_range", l1_oob, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_pool_engine.md
Name: conv_pool_engine

Overview:
- Parametrised successor of the layer-0/layer-1 image convolution engine.
- Reads an N×N image from the image ROM and computes a 3×3 zero-padded convolution with bias and ReLU. It writes layer 0 to the result memory (csel=1), then optionally runs 2×2 stride-2 max pooling into layer 1 (csel=3).
- Adds over the previous generation: run-time loadable kernel and bias, output saturation, pooling bypass, correct layer-1 addressing, and restart without reset.

Parameters:
- AW, 6: log2 of image side; N = 2^AW; image and memory addresses are 2*AW bits.
- DW, 20: pixel, coefficient and result width; signed two's complement.
- FRAC, 16: fraction bits of pixels, coefficients, bias and results.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ready  in  1  frame-start request; sampled only in IDLE.
- pool_en  in  1  1 = run pooling pass after layer 0; sampled with ready.
- kwr  in  1  coefficient write strobe; ignored while busy.
- kaddr  in  4  0–8 = K0..K8 (row-major, top-left first), 9 = bias; 10–15 ignored.
- kdata  in  DW  coefficient/bias value.
- busy  out  1  high from the cycle after accepted ready until the frame completes.
- iaddr  out  2*AW  image address {y,x}.
- idata  in  DW  image data, valid the cycle after iaddr.
- crd  out  1  result-memory read strobe.
- caddr_rd  out  2*AW  result read address.
- cdata_rd  in  DW  read data, valid the cycle after caddr_rd/crd.
- cwr  out  1  result write strobe.
- caddr_wr  out  2*AW  result write address.
- cdata_wr  out  DW  result write data.
- csel  out  3  memory select: 0 = none, 1 = layer 0, 3 = layer 1.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; busy, crd, cwr, csel, iaddr, caddr_rd, caddr_wr, cdata_wr all go to 0.
  - Kernel registers reload defaults K0..K8 = 0A89E, 092D5, 06D43, 01004, F8F71, F6E54, FA6D7, FC834, FAC19; bias = 01310 (hex, DW=20).
- States: IDLE → CONV_RD → CONV_WR → (loop) → POOL_RD → POOL_MAX → POOL_WR → (loop) → DONE → IDLE.
- IDLE:
  - ready=1 latches pool_en, clears x and y, enters CONV_RD; busy=1 the next cycle.
  - kwr writes the register at kaddr. ready and kwr in the same cycle: the write lands first and is used by the frame.
- CONV_RD, 12 cycles per pixel (counter 0–11):
  - Counters 0–8 issue the 9 neighbour addresses in row-major order.
  - Counters 2–10 accumulate the registered idata × Kk.
  - Taps outside the image (x-1<0, x+1>N-1, y-1<0, y+1>N-1) contribute exactly 0; iaddr is still driven (wrapped) but the data is discarded.
  - Counter 11 adds bias << FRAC.
- Arithmetic:
  - Products are 2*DW bits; the accumulator is 2*DW+4 bits signed.
  - Result = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - If acc < 0, output 0 (ReLU).
  - If the result exceeds 2^(DW-1)-1, output 2^(DW-1)-1 (saturate).
- CONV_WR, 1 cycle:
  - Registers cwr=1, csel=1, caddr_wr={y,x}, cdata_wr=result, so the write is visible the following cycle.
  - Advances x; at x=N-1 wraps x to 0 and increments y.
  - After pixel (N-1,N-1), goes to POOL_RD if pool_en, else DONE.
  - 13 cycles per pixel, so layer 0 takes 13·N² cycles.
- POOL_RD, 5 cycles:
  - crd=1, csel=1; reads {y,x}, {y,x+1}, {y+1,x}, {y+1,x+1} with x, y even.
  - Keeps a running signed max of cdata_rd.
- POOL_MAX, 1 cycle: final compare.
- POOL_WR, 1 cycle:
  - cwr=1, csel=3, caddr_wr={y>>1,x>>1} zero-extended to 2*AW bits, cdata_wr=max.
  - x += 2; at x=N-2 wraps x to 0 and adds 2 to y.
  - After (N-2,N-2), goes to DONE. 7 cycles per output.
- DONE:
  - busy=0 the next cycle; returns to IDLE.
  - All strobes 0 and csel=0 whenever not in a write or read state.
- ready while busy is ignored.
- kwr while busy is ignored; registers are unchanged.
- cwr and crd are never high in the same cycle.

Test Plan:
- All-zero image, default kernel, pool_en=0 → 4096 layer-0 writes, each 00000 + bias rounded = 01310 at every address. busy high for exactly 13·4096 cycles; csel=3 never seen.
- Load kernel K4=10000 (1.0), others 0, bias 0; image idata=addr[11:0]<<4 → layer 0 equals input, except negative values clamp to 0; corner pixel (0,0) ignores out-of-bounds taps.
- Load all K=10000, bias 0, image all 7FFFF → interior pixels saturate to 7FFFF; corner (0,0) also saturates. Check no wrap-around to a negative value.
- pool_en=1 with the identity kernel and a ramp image → layer 1 has 1024 writes at caddr_wr 0–1023. Entry {0,0} = max of L0 addresses 0, 1, 64, 65.
- Assert reset mid-CONV_RD (pixel ~100) → next cycle all outputs 0 and kernel reverts to defaults; a following ready runs a full clean frame.
- kwr pulsed while busy with kaddr=4 → the frame result is unchanged. Two back-to-back frames without reset both complete with busy returning to 0.
